toupper_arb: RTL and testbench
==============================

# toupper_arb

Round-robin scheduler that shares one ASCII upper-case conversion unit between `N_REQ` byte-stream requesters. Each requester offers one byte per valid/ready handshake. A granted byte passes through the conversion logic and lands in a single-entry output register tagged with its source index. A saturating counter tracks how many bytes were actually changed. The block sits between the character sources (UART RX, host FIFO) and the downstream text consumer.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters; legal range 2..8.
- `CNT_W`, 16: width of the changed-byte counter.

Ports:
- `clk`: input, 1. Single clock; all state updates on its rising edge.
- `rst_n`: input, 1. Reset, asynchronous and active-low.
- `conv_en`: input, 1. 1 = convert lower to upper; 0 = pass bytes unchanged.
- `req_valid`: input, N_REQ. Per-requester byte valid.
- `req_data`: input, 8*N_REQ. Requester i occupies bits [8i+7:8i].
- `req_ready`: output, N_REQ. Per-requester accept; at most one bit set.
- `out_valid`: output, 1. Output register holds a byte.
- `out_ready`: input, 1. Downstream accept.
- `out_data`: output, 8. Converted byte.
- `out_src`: output, $clog2(N_REQ). Index of the source requester.
- `out_changed`: output, 1. 1 if `out_data` differs from the input byte.
- `clr_count`: input, 1. Synchronous clear of `conv_count`.
- `conv_count`: output, CNT_W. Saturating count of changed bytes.

## Operation
- Conversion (combinational): if `conv_en` and byte in 0x61..0x7A, output = byte − 0x20 (bit 5 cleared); all other bytes pass unchanged, including bit 7 set and 0x60/0x7B. `changed` = conversion applied.
- Output slot FSM, two states:
  - EMPTY (`out_valid`=0): loads on any input handshake → FULL.
  - FULL: `out_ready`=1 with no new handshake → EMPTY. `out_ready`=1 with a new handshake → stays FULL with new contents (back-to-back). `out_ready`=0 → holds.
- `load` = !out_valid || out_ready.
- Arbitration: round-robin over requesters with `req_valid`=1, searched starting at `last_grant`+1 mod N_REQ. `req_ready[i]` = load && grant[i]. `req_ready` is 0 for all requesters when `load`=0, and depends combinationally on `req_valid` and `out_ready`.
- On input handshake of requester i:
  - register the converted byte, i, and the `changed` flag;
  - `last_grant` ← i.
  - `last_grant` is unchanged when no handshake occurs.
- A requester holding `req_valid` is granted within N_REQ handshakes (no starvation).
- `conv_en` is sampled in the handshake cycle. Changing it never alters a byte already in the output register.
- Counter: +1 on each handshake with `changed`=1; saturates at 2^CNT_W−1. `clr_count` in the same cycle as an increment wins (result 0).
- Reset values:
  - `out_valid`=0, `out_data`=0x00, `out_src`=0, `out_changed`=0, `conv_count`=0.
  - `last_grant`=N_REQ−1, so requester 0 wins first.
- Asserting `rst_n` low mid-transfer discards the held byte immediately; nothing is replayed.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 byte/cycle while `out_ready`=1.
- `out_data`, `out_src`, `out_changed` are stable while `out_valid` && !`out_ready`.
- All outputs except `req_ready` are registered.

## Structure
- Shared package `toupper_pkg`: constants `ASCII_LOWER_A`=8'h61, `ASCII_LOWER_Z`=8'h7A, `ASCII_CASE_OFFSET`=8'h20.
- Sub-module `ascii_upper`: purely combinational, 8-bit in, `en` in, 8-bit out, `changed` out. The top level instantiates it once after the grant mux.
- Arbiter, output slot and counter live in `toupper_arb`.

## Test plan
- Single requester:
  - stimulus: req0 sends 0x61, 0x7A, 0x41, 0x60, 0x7B, 0xE1 with `conv_en`=1 and `out_ready`=1;
  - required: outputs 0x41, 0x5A, 0x41, 0x60, 0x7B, 0xE1; `out_changed` 1,1,0,0,0,0; `conv_count`=2.
- Round-robin:
  - stimulus: both requesters valid continuously (req0 'a', req1 'b') after reset;
  - required: `out_src` sequence 0,1,0,1; `out_data` 0x41,0x42 alternating; one byte per cycle.
- Backpressure:
  - stimulus: `out_ready`=0 for 5 cycles while holding 0x43 from req1;
  - required: output stable, `req_ready`=0; `out_ready`=1 with req0 valid gives back-to-back load next cycle.
- Bypass:
  - stimulus: `conv_en`=0, byte 0x71;
  - required: `out_data`=0x71, `out_changed`=0, counter unchanged.
- Counter:
  - stimulus: CNT_W=4, 17 changed bytes;
  - required: `conv_count`=15. `clr_count` together with a changed byte gives 0.
- Reset mid-operation:
  - stimulus: assert `rst_n`=0 while `out_valid`=1 mid-cycle;
  - required: `out_valid`=0 asynchronously. After release, req0 gets priority over req1 when both are valid.

Source files
------------

// File: rtl/toupper_pkg.sv
// Shared constants, slot state encoding and ASCII helper for the toupper arbiter.
package toupper_pkg;

    localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

    // Output slot states: EMPTY means no byte held, FULL means out_valid is high.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // True for 'a'..'z' only. Bytes with bit 7 set and the neighbours 0x60/0x7B are excluded.
    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z);
    endfunction

endpackage

// File: rtl/toupper_arb_if.sv
// Requester and output handshake bundle for toupper_arb.
// The DUT connects through the slave modport. Sources and the sink connect through master.
interface toupper_arb_if #(
    parameter int N_REQ = 2
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic [SRC_W-1:0]   out_src;
    logic               out_changed;

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src,
        output out_changed
    );

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  out_changed
    );

endinterface

// File: rtl/toupper_arb_ascii_upper.sv
// Combinational lower-to-upper case converter.
// The changed output is high exactly when the byte was modified.
module ascii_upper
    import toupper_pkg::*;
(
    input  logic [7:0] in_byte,
    input  logic       en,
    output logic [7:0] out_byte,
    output logic       changed
);

    // Only 'a'..'z' are touched. Subtracting the offset clears bit 5.
    always_comb begin
        changed  = en && is_lower(in_byte);
        out_byte = changed ? (in_byte - ASCII_CASE_OFFSET) : in_byte;
    end

endmodule

// File: rtl/toupper_arb.sv
// Round-robin scheduler that shares one ascii_upper converter between N_REQ byte sources.
// The output is a single-entry register tagged with the source index.
// A saturating counter tracks how many bytes the converter changed.
// N_REQ is intended for the range 2..8.
module toupper_arb
    import toupper_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             conv_en,
    input  logic             clr_count,
    output logic [CNT_W-1:0] conv_count,
    toupper_arb_if.slave     bus
);

    localparam int SRC_W = $clog2(N_REQ);

    // Slot and arbitration state.
    logic [0:0]       state_q,      state_d;
    logic [7:0]       data_q,       data_d;
    logic [SRC_W-1:0] src_q,        src_d;
    logic             changed_q,    changed_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] count_q,      count_d;

    // Combinational datapath.
    logic             load;
    logic             grant_found;
    logic [SRC_W-1:0] grant_idx;
    logic [7:0]       req_bytes [N_REQ];
    logic [7:0]       sel_byte;
    logic [7:0]       conv_byte;
    logic             conv_changed;
    logic             handshake;

    // The slot can accept a byte when it is empty, or when it is being drained this cycle.
    assign load = (state_q == ST_EMPTY) || bus.out_ready;

    // Split the packed request bus into one byte per requester.
    // Drive each ready from the single winning index.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_bytes[gi]    = bus.req_data[8*gi +: 8];
            assign bus.req_ready[gi] = load && grant_found && (grant_idx == SRC_W'(gi));
        end
    endgenerate

    // Round-robin search starting at last_grant+1.
    // The loop runs from the farthest offset down to the nearest, so the requester closest after the last winner is assigned last and wins.
    always_comb begin
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = (int'(last_grant_q) + k) % N_REQ;
            if (bus.req_valid[SRC_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(cand);
            end
        end
    end

    assign handshake = load && grant_found;
    assign sel_byte  = req_bytes[grant_idx];

    // One shared converter after the grant mux. conv_en is sampled only in the handshake cycle.
    ascii_upper u_upper (
        .in_byte  (sel_byte),
        .en       (conv_en),
        .out_byte (conv_byte),
        .changed  (conv_changed)
    );

    // Next-state logic for the slot FSM, the held byte and the round-robin pointer.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        src_d        = src_q;
        changed_d    = changed_q;
        last_grant_d = last_grant_q;
        if (handshake) begin
            state_d      = ST_FULL;
            data_d       = conv_byte;
            src_d        = grant_idx;
            changed_d    = conv_changed;
            last_grant_d = grant_idx;
        end else if (state_q == ST_FULL && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Saturating changed-byte counter. A clear in the same cycle as an increment wins.
    always_comb begin
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (handshake && conv_changed && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Register all state. Reset drops any held byte, and requester 0 is next in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            data_q       <= 8'h00;
            src_q        <= '0;
            changed_q    <= 1'b0;
            last_grant_q <= SRC_W'(N_REQ - 1);
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            src_q        <= src_d;
            changed_q    <= changed_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

    assign bus.out_valid   = (state_q == ST_FULL);
    assign bus.out_data    = data_q;
    assign bus.out_src     = src_q;
    assign bus.out_changed = changed_q;
    assign conv_count      = count_q;

endmodule

// File: tb/tb_toupper_arb.sv
// Directed bench for toupper_arb.
// It uses two requesters and a 4-bit counter so that saturation is reachable.
// A queue-free transaction model checks the DUT every cycle.
// Literal expectations per scenario pin the model itself.
module tb_toupper_arb;

    localparam int NR = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          conv_en = 1'b1;
    logic          clr_count = 1'b0;
    logic [CW-1:0] conv_count;

    toupper_arb_if #(.N_REQ(NR)) bus ();

    toupper_arb #(.N_REQ(NR), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conv_en    (conv_en),
        .clr_count  (clr_count),
        .conv_count (conv_count),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic          m_valid = 1'b0;
    logic [7:0]    m_data = 8'h00;
    int            m_src = 0;
    logic          m_chg = 1'b0;
    int            m_last = NR - 1;
    int            m_count = 0;

    function automatic logic [7:0] upcase(input logic [7:0] b, input logic en);
        if (en && b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
        return b;
    endfunction

    function automatic logic [7:0] byte_of(input int i);
        return bus.req_data[8*i +: 8];
    endfunction

    // Index of the requester that hands over a byte this cycle, or -1 if none does.
    function automatic int model_hs_idx();
        if (m_valid && !bus.out_ready) return -1;
        for (int k = 1; k <= NR; k++) begin
            if (bus.req_valid[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    function automatic int model_ready();
        if (model_hs_idx() < 0) return 0;
        return 1 << model_hs_idx();
    endfunction

    function automatic logic model_hs_changed();
        if (model_hs_idx() < 0) return 1'b0;
        return upcase(byte_of(model_hs_idx()), conv_en) != byte_of(model_hs_idx());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_src   <= 0;
            m_chg   <= 1'b0;
            m_last  <= NR - 1;
            m_count <= 0;
        end else begin
            if (model_hs_idx() >= 0) begin
                m_valid <= 1'b1;
                m_src   <= model_hs_idx();
                m_data  <= upcase(byte_of(model_hs_idx()), conv_en);
                m_chg   <= model_hs_changed();
                m_last  <= model_hs_idx();
            end else if (bus.out_ready) begin
                m_valid <= 1'b0;
            end
            if (clr_count) m_count <= 0;
            else if (model_hs_changed() && m_count < (1 << CW) - 1) m_count <= m_count + 1;
        end
    end

    // ---------------- per-cycle compare and transfer log ----------------
    int got_data[$];
    int got_src[$];
    int got_chg[$];
    int got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", int'(bus.req_ready), model_ready());
            chk("out_valid", int'(bus.out_valid), int'(m_valid));
            if (m_valid) begin
                chk("out_data", int'(bus.out_data), int'(m_data));
                chk("out_src", int'(bus.out_src), m_src);
                chk("out_changed", int'(bus.out_changed), int'(m_chg));
            end
            chk("conv_count", int'(conv_count), m_count);
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(int'(bus.out_data));
                got_src.push_back(int'(bus.out_src));
                got_chg.push_back(int'(bus.out_changed));
                got_cyc.push_back(cyc);
                $display("xfer cyc=%0d src=%0d data=0x%02h changed=%0d",
                         cyc, bus.out_src, bus.out_data, bus.out_changed);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic ordy, input logic cen, input logic clr);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.req_data  = {d1, d0};
        bus.out_ready = ordy;
        conv_en       = cen;
        clr_count     = clr;
    endtask

    task automatic idle();
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic clear_log();
        got_data.delete();
        got_src.delete();
        got_chg.delete();
        got_cyc.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] t1_in  [6] = '{8'h61, 8'h7A, 8'h41, 8'h60, 8'h7B, 8'hE1};
    logic [7:0] t1_out [6] = '{8'h41, 8'h5A, 8'h41, 8'h60, 8'h7B, 8'hE1};
    logic       t1_chg [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        #2;
        // Reset values.
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_src", int'(bus.out_src), 0);
        chk("rst_out_changed", int'(bus.out_changed), 0);
        chk("rst_conv_count", int'(conv_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester: the conversion boundaries.
        clear_log();
        for (int i = 0; i < 6; i++) drive(2'b01, t1_in[i], 8'h00, 1'b1, 1'b1, 1'b0);
        idle();
        idle();
        @(negedge clk);
        chk("t1_num", got_data.size(), 6);
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            chk($sformatf("t1_data%0d", i), got_data[i], int'(t1_out[i]));
            chk($sformatf("t1_chg%0d", i), got_chg[i], int'(t1_chg[i]));
        end
        chk("t1_count", int'(conv_count), 2);

        // Round-robin from reset: req0 'a', req1 'b'.
        do_reset();
        clear_log();
        repeat (4) drive(2'b11, 8'h61, 8'h62, 1'b1, 1'b1, 1'b0);
        idle();
        idle();
        @(negedge clk);
        chk("rr_num", got_data.size(), 4);
        if (got_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_src%0d", i), got_src[i], i % 2);
                chk($sformatf("rr_data%0d", i), got_data[i], (i % 2 == 0) ? 8'h41 : 8'h42);
            end
            chk("rr_rate", got_cyc[3] - got_cyc[0], 3);
        end

        // Backpressure: hold 0x43 from req1, then a back-to-back load from req0.
        clear_log();
        drive(2'b10, 8'h00, 8'h43, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 8'h00, 8'h43, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_data", int'(bus.out_data), 8'h43);
            chk("bp_src", int'(bus.out_src), 1);
            chk("bp_ready", int'(bus.req_ready), 0);
        end
        drive(2'b01, 8'h64, 8'h00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_ready_go", int'(bus.req_ready), 1);
        idle();
        @(negedge clk);
        chk("bp_b2b_valid", int'(bus.out_valid), 1);
        chk("bp_b2b_data", int'(bus.out_data), 8'h44);
        chk("bp_b2b_src", int'(bus.out_src), 0);
        idle();
        chk("bp_num", got_data.size(), 2);

        // Bypass: conv_en=0 on a lower-case byte. The count stays at 5.
        drive(2'b01, 8'h71, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("byp_data", int'(bus.out_data), 8'h71);
        chk("byp_changed", int'(bus.out_changed), 0);
        chk("byp_count", int'(conv_count), 5);

        // Counter saturation and clear priority.
        drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        repeat (17) drive(2'b01, 8'h61, 8'h00, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("cnt_sat", int'(conv_count), 15);
        drive(2'b01, 8'h61, 8'h00, 1'b1, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("cnt_clr_wins", int'(conv_count), 0);
        drive(2'b01, 8'h61, 8'h00, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("cnt_after_clr", int'(conv_count), 1);

        // A held byte ignores later conv_en changes. A mid-cycle reset then drops it.
        drive(2'b01, 8'h78, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold_data", int'(bus.out_data), 8'h58);
        chk("hold_changed", int'(bus.out_changed), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_data  = {8'h71, 8'h70};
        bus.out_ready = 1'b1;
        conv_en       = 1'b1;
        #1;
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_data", int'(bus.out_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("arst_first_src", int'(bus.out_src), 0);
        chk("arst_first_data", int'(bus.out_data), 8'h50);
        idle();
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
